// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - RVFI commit record type, opcode constants and halt test
package rvfi_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic            load_regfile;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
    } rvfi_word_t;

    // A branch or jal that targets itself is the conventional "stop here" idiom.
    function automatic logic is_halt(rvfi_word_t w);
        return ((w.inst[6:0] == OP_BR) || (w.inst[6:0] == OP_JAL)) &&
               (w.pc_wdata == w.pc_rdata);
    endfunction

endpackage

// File: rtl/rvfi_commit_fifo.sv
// rtl/rvfi_commit_fifo.sv - multi-write, single-read circular record buffer
module rvfi_commit_fifo
    import rvfi_pkg::*;
#(
    parameter int CW    = 2,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CW-1:0]             wr_valid,
    input  rvfi_word_t [CW-1:0]       wr_word,
    input  logic                      rd_en,
    output rvfi_word_t                head_word,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    rvfi_word_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] num_wr;
    logic [AW-1:0] waddr [CW];

    // Prefix sum over valid lanes packs gapped lanes into consecutive slots.
    always_comb begin
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < CW; i++) begin
            waddr[i] = wr_ptr[AW-1:0] + acc[AW-1:0];
            acc      = acc + PW'(wr_valid[i]);
        end
        num_wr = acc;
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign head_word = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + num_wr;
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CW; i++) begin
            if (wr_valid[i]) begin
                mem[waddr[i]] <= wr_word[i];
            end
        end
    end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// rtl/rvfi_commit_serializer.sv - serializes ROB commits into ordered RVFI records
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int ORDER_W      = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COMMIT_WIDTH-1:0]       commit_valid_i,
    input  rvfi_word_t [COMMIT_WIDTH-1:0] commit_word_i,
    output logic                          commit_ready_o,
    output logic                          out_commit_o,
    output rvfi_word_t                    out_word_o,
    output logic [ORDER_W-1:0]            out_order_o,
    output logic                          out_halt_o,
    output logic                          overflow_o,
    output logic [$clog2(DEPTH):0]        occupancy_o
);

    rvfi_word_t                head;
    logic                      empty;
    logic                      full;
    logic [$clog2(DEPTH):0]    count;
    logic [COMMIT_WIDTH-1:0]   wr_valid;
    logic                      head_halt;
    logic                      halted_q;
    logic                      overflow_q;
    logic [ORDER_W-1:0]        order_q;

    // A whole retire group is admitted or dropped together; partial acceptance would
    // break program order in the trace.
    assign commit_ready_o = ((DEPTH - int'(count)) >= COMMIT_WIDTH);
    assign wr_valid       = (commit_ready_o && !full) ? commit_valid_i : '0;

    rvfi_commit_fifo #(
        .CW    (COMMIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_word   (commit_word_i),
        .rd_en     (out_commit_o),
        .head_word (head),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    assign head_halt    = is_halt(head);
    assign out_commit_o = !empty && !halted_q;
    assign out_halt_o   = halted_q || (out_commit_o && head_halt);
    assign out_order_o  = order_q;
    assign overflow_o   = overflow_q;
    assign occupancy_o  = count;

    always_comb begin
        out_word_o = '0;
        if (out_commit_o) begin
            out_word_o = head;
            if ((head.rd_addr == 5'd0) || !head.load_regfile) begin
                out_word_o.rd_wdata = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
            order_q    <= '0;
        end else begin
            if ((|commit_valid_i) && !commit_ready_o) begin
                overflow_q <= 1'b1;
            end
            if (out_commit_o) begin
                order_q <= order_q + ORDER_W'(1);
                if (head_halt) begin
                    halted_q <= 1'b1;
                end
            end
        end
    end

endmodule
